regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 32x32 register file between NREQ write-back

---
 rtl/rf_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 73 +++++++
 tb/tb_regfile_wb_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file types and constants
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = 5'd0;

  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rtl/regfile_wb_arbiter_rr.sv - N-wide round-robin grant with rotating priority pointer
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  valid,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          grant_any
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  int            j;

  // Search from the pointer upward with wrap; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    ptr_next  = ptr;
    idx       = '0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      idx = PW'(j);
      if (en && !grant_any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
        ptr_next   = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

  // Priority pointer moves just past the winner on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-back arbiter feeding the register file write port; WB_FWD_EN adds same-cycle bypass outputs
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic              i_stall,
  output logic              o_rf_we,
  output logic [AW-1:0]     o_rf_waddr,
  output logic [DW-1:0]     o_rf_wdata
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0]     i_rd_addr1,
  input  logic [AW-1:0]     i_rd_addr2,
  output logic              o_fwd_hit1,
  output logic              o_fwd_hit2,
  output logic [DW-1:0]     o_fwd_data
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Reset is folded into the enable so no ready can escape while held in reset.
  rr_arbiter #(.N(NREQ), .PW(PW)) u_rr (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .valid     (i_req_valid),
    .en        (i_rst_n && !i_stall),
    .grant     (o_req_ready),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  assign sel_addr = i_req_addr[gnt_idx*AW +: AW];
  assign sel_data = i_req_data[gnt_idx*DW +: DW];

  // Output stage: load the winner, drop x0 writes, idle clears we, stall holds all.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= '0;
      o_rf_wdata <= '0;
    end else if (!i_stall) begin
      if (gnt_any) begin
        o_rf_we    <= (sel_addr != AW'(RF_ZERO_REG));
        o_rf_waddr <= sel_addr;
        o_rf_wdata <= sel_data;
      end else begin
        o_rf_we    <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  assign o_fwd_hit1 = o_rf_we && (o_rf_waddr == i_rd_addr1) && (i_rd_addr1 != '0);
  assign o_fwd_hit2 = o_rf_we && (o_rf_waddr == i_rd_addr2) && (i_rd_addr2 != '0);
  assign o_fwd_data = o_rf_wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench with behavioural write-back model
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [NREQ-1:0]    i_req_valid;
  logic [NREQ*AW-1:0] i_req_addr;
  logic [NREQ*DW-1:0] i_req_data;
  logic [NREQ-1:0]    o_req_ready;
  logic               i_stall;
  logic               o_rf_we;
  logic [AW-1:0]      o_rf_waddr;
  logic [DW-1:0]      o_rf_wdata;
`ifdef WB_FWD_EN
  logic [AW-1:0]      i_rd_addr1;
  logic [AW-1:0]      i_rd_addr2;
  logic               o_fwd_hit1;
  logic               o_fwd_hit2;
  logic [DW-1:0]      o_fwd_data;
  logic               s_hit1, s_hit2;
  logic [DW-1:0]      s_fdata;
`endif

  always #5 i_clk = ~i_clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .i_stall     (i_stall),
    .o_rf_we     (o_rf_we),
    .o_rf_waddr  (o_rf_waddr),
    .o_rf_wdata  (o_rf_wdata)
`ifdef WB_FWD_EN
    ,
    .i_rd_addr1  (i_rd_addr1),
    .i_rd_addr2  (i_rd_addr2),
    .o_fwd_hit1  (o_fwd_hit1),
    .o_fwd_hit2  (o_fwd_hit2),
    .o_fwd_data  (o_fwd_data)
`endif
  );

  // requester-side state
  logic          rv  [NREQ];
  logic [AW-1:0] ra  [NREQ];
  logic [DW-1:0] rdt [NREQ];
  logic          stall_r;
  logic          rst_r;
  logic [AW-1:0] rd1_r, rd2_r;

  // behavioural model of the write stage
  int            m_ptr;
  int            m_gnt;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // samples
  logic [NREQ-1:0] s_ready;
  logic            s_we;
  logic [AW-1:0]   s_waddr;
  logic [DW-1:0]   s_wdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick();
    if (!rst_r || stall_r) return -1;
    for (int i = 0; i < NREQ; i++) begin
      if (rv[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      i_req_valid[k]          = rv[k];
      i_req_addr[k*AW +: AW]  = ra[k];
      i_req_data[k*DW +: DW]  = rdt[k];
    end
    i_stall = stall_r;
    i_rst_n = rst_r;
`ifdef WB_FWD_EN
    i_rd_addr1 = rd1_r;
    i_rd_addr2 = rd2_r;
`endif
  endtask

  // One cycle: drive, sample and compare at negedge, advance the model at posedge.
  task automatic tick();
    logic [NREQ-1:0] exp_ready;
    drive();
    @(negedge i_clk);
    m_gnt = model_pick();
    exp_ready = '0;
    if (m_gnt >= 0) exp_ready[m_gnt] = 1'b1;
    s_ready = o_req_ready;
    s_we    = o_rf_we;
    s_waddr = o_rf_waddr;
    s_wdata = o_rf_wdata;
    check("ready", 64'(s_ready), 64'(exp_ready));
    check("we",    64'(s_we),    64'(m_we));
    check("waddr", 64'(s_waddr), 64'(m_addr));
    check("wdata", 64'(s_wdata), 64'(m_data));
`ifdef WB_FWD_EN
    s_hit1  = o_fwd_hit1;
    s_hit2  = o_fwd_hit2;
    s_fdata = o_fwd_data;
    check("fwd_hit1", 64'(s_hit1), 64'(m_we && m_addr == rd1_r && rd1_r != 0));
    check("fwd_hit2", 64'(s_hit2), 64'(m_we && m_addr == rd2_r && rd2_r != 0));
    check("fwd_data", 64'(s_fdata), 64'(m_data));
`endif
    @(posedge i_clk);
    if (rst_r && !stall_r) begin
      if (m_gnt >= 0) begin
        m_we   = (ra[m_gnt] != 0);
        m_addr = ra[m_gnt];
        m_data = rdt[m_gnt];
        m_ptr  = (m_gnt + 1) % NREQ;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      rv[k] = 1'b1; ra[k] = AW'(k + 1); rdt[k] = 32'h100 + k;
    end
    stall_r = 1'b0;
    rd1_r = '0;
    rd2_r = '0;
    rst_r = 1'b0;
    model_reset();
    drive();

    // 1: reset with all valids high
    tick();
    check("t1_ready", 64'(s_ready), 64'h0);
    check("t1_we",    64'(s_we),    64'h0);
    check("t1_waddr", 64'(s_waddr), 64'h0);
    rst_r = 1'b1;
    for (int k = 0; k < NREQ; k++) rv[k] = 1'b0;

    // 2: single request from k=1
    rv[1] = 1'b1; ra[1] = 5'd5; rdt[1] = 32'hDEADBEEF;
    tick();
    check("t2_ready", 64'(s_ready), 64'h2);
    rv[1] = 1'b0;
    tick();
    check("t2_we",    64'(s_we),    64'h1);
    check("t2_waddr", 64'(s_waddr), 64'h5);
    check("t2_wdata", 64'(s_wdata), 64'hDEADBEEF);
    tick();
    check("t2_we_off", 64'(s_we), 64'h0);

    // 4: write to x0 is granted but not issued
    rv[2] = 1'b1; ra[2] = 5'd0; rdt[2] = 32'h1234;
    tick();
    check("t4_ready", 64'(s_ready), 64'h4);
    rv[2] = 1'b0;
    tick();
    check("t4_we", 64'(s_we), 64'h0);

    // 3: all valid continuously, rotation 0,1,2,0,1,2
    for (int k = 0; k < NREQ; k++) begin
      rv[k] = 1'b1; ra[k] = AW'(10 + k); rdt[k] = 32'hA0000000 + k;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t3_ready", 64'(s_ready), 64'(1 << (i % 3)));
      if (i > 0) begin
        check("t3_we",    64'(s_we),    64'h1);
        check("t3_waddr", 64'(s_waddr), 64'(10 + i - 1));
      end
      ra[i % 3]  = AW'(10 + i + 3);
      rdt[i % 3] = 32'hA0000000 + i + 3;
    end

    // 5: stall holds the stage and blocks grants
    rv[1] = 1'b0; rv[2] = 1'b0;
    stall_r = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_ready", 64'(s_ready), 64'h0);
      check("t5_we",    64'(s_we),    64'h1);
      check("t5_waddr", 64'(s_waddr), 64'd15);
    end
    stall_r = 1'b0;
    tick();
    check("t5_grant0", 64'(s_ready), 64'h1);
    rv[0] = 1'b0;
    tick();
    check("t5_waddr2", 64'(s_waddr), 64'd16);

`ifdef WB_FWD_EN
    // 6: forwarding of the pending write
    rv[0] = 1'b1; ra[0] = 5'd7; rdt[0] = 32'h55;
    tick();
    rv[0] = 1'b0;
    rd1_r = 5'd7; rd2_r = 5'd0;
    tick();
    check("t6_hit1", 64'(s_hit1),  64'h1);
    check("t6_hit2", 64'(s_hit2),  64'h0);
    check("t6_data", 64'(s_fdata), 64'h55);
`endif

    // randomized traffic with protocol-respecting requesters and one mid-stream reset
    for (int n = 0; n < 400; n++) begin
      stall_r = ($urandom_range(0, 7) == 0);
      rd1_r = AW'($urandom_range(0, 7));
      rd2_r = AW'($urandom_range(0, 7));
      if (n == 200 || n == 201) begin
        rst_r = 1'b0;
        model_reset();
      end else begin
        rst_r = 1'b1;
      end
      tick();
      for (int k = 0; k < NREQ; k++) begin
        if (m_gnt == k) rv[k] = 1'b0;
        if (!rv[k] && $urandom_range(0, 1) == 1) begin
          rv[k]  = 1'b1;
          ra[k]  = AW'($urandom_range(0, 7));
          rdt[k] = $urandom;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
